// File: rtl/stopwatch_ctrl_if.sv
// Control/strobe bundle between the button front end, the stopwatch sequencer
// and the digit counters / 7-seg mux.
interface stopwatch_ctrl_if;
    logic       pause_pulse;
    logic       clear_pulse;
    logic       adj_level;
    logic       sel_level;
    logic       count_tick;
    logic       adj_sec_tick;
    logic       adj_min_tick;
    logic       clear;
    logic [1:0] scan_idx;
    logic [3:0] an_mask;
    logic [1:0] mode;

    // Front end side: drives button levels/pulses, observes strobes.
    modport master (
        output pause_pulse, clear_pulse, adj_level, sel_level,
        input  count_tick, adj_sec_tick, adj_min_tick, clear, scan_idx, an_mask, mode
    );

    // Sequencer side.
    modport slave (
        input  pause_pulse, clear_pulse, adj_level, sel_level,
        output count_tick, adj_sec_tick, adj_min_tick, clear, scan_idx, an_mask, mode
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch control sequencer: run/pause/adjust mode FSM plus single-clock
// enable strobes for counting, adjusting, clearing, display scan and blink.
module stopwatch_ctrl #(
    parameter int DIV_NORMAL = 100_000_000,
    parameter int DIV_ADJUST = 50_000_000,
    parameter int DIV_BLINK  = 25_000_000,
    parameter int DIV_SCAN   = 100_000,
    parameter int CW         = 27
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PAUSED  = 2'b01,
        ADJ_SEC = 2'b10,
        ADJ_MIN = 2'b11
    } mode_e;

    localparam logic [CW-1:0] NORM_LAST  = CW'(DIV_NORMAL - 1);
    localparam logic [CW-1:0] ADJ_LAST   = CW'(DIV_ADJUST - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(DIV_BLINK - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(DIV_SCAN - 1);

    mode_e         mode_q, mode_d;
    logic          paused_q, paused_d;
    logic [CW-1:0] norm_q, norm_d;
    logic [CW-1:0] adj_q, adj_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic          blink_q, blink_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic          count_tick_q, count_tick_d;
    logic          adj_sec_tick_q, adj_sec_tick_d;
    logic          adj_min_tick_q, adj_min_tick_d;
    logic          clear_q, clear_d;
    logic [3:0]    an_mask_q, an_mask_d;
    logic          in_adj;

    // Both adjust encodings have the MSB set.
    assign in_adj = mode_q[1];

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mode_d   = mode_q;
        paused_d = paused_q;
        if (bus.adj_level) begin
            mode_d = bus.sel_level ? ADJ_MIN : ADJ_SEC;
        end else if (in_adj) begin
            mode_d = paused_q ? PAUSED : RUN;
        end else if (bus.pause_pulse && !bus.clear_pulse) begin
            paused_d = (mode_q == RUN);
            mode_d   = (mode_q == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        norm_d         = norm_q;
        count_tick_d   = 1'b0;
        adj_d          = '0;
        adj_sec_tick_d = 1'b0;
        adj_min_tick_d = 1'b0;
        clear_d        = bus.clear_pulse;

        // Normal divider holds outside RUN so the partial second survives pause/adjust.
        if (bus.clear_pulse) begin
            norm_d = '0;
        end else if (mode_q == RUN) begin
            if (norm_q == NORM_LAST) begin
                norm_d       = '0;
                count_tick_d = 1'b1;
            end else begin
                norm_d = norm_q + CW'(1);
            end
        end

        if (!bus.clear_pulse && in_adj) begin
            if (adj_q == ADJ_LAST) begin
                adj_sec_tick_d = (mode_q == ADJ_SEC);
                adj_min_tick_d = (mode_q == ADJ_MIN);
            end else begin
                adj_d = adj_q + CW'(1);
            end
        end

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + CW'(1);
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end

        scan_idx_d = scan_idx_q;
        scan_cnt_d = scan_cnt_q + CW'(1);
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end

        // Mask is built from next-state values so it lines up with the registered mode.
        case (mode_d)
            ADJ_MIN: an_mask_d = {blink_d, blink_d, 2'b00};
            ADJ_SEC: an_mask_d = {2'b00, blink_d, blink_d};
            default: an_mask_d = 4'b0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q         <= RUN;
            paused_q       <= 1'b0;
            norm_q         <= '0;
            adj_q          <= '0;
            blink_cnt_q    <= '0;
            scan_cnt_q     <= '0;
            blink_q        <= 1'b0;
            scan_idx_q     <= 2'd0;
            count_tick_q   <= 1'b0;
            adj_sec_tick_q <= 1'b0;
            adj_min_tick_q <= 1'b0;
            clear_q        <= 1'b0;
            an_mask_q      <= 4'b0000;
        end else begin
            mode_q         <= mode_d;
            paused_q       <= paused_d;
            norm_q         <= norm_d;
            adj_q          <= adj_d;
            blink_cnt_q    <= blink_cnt_d;
            scan_cnt_q     <= scan_cnt_d;
            blink_q        <= blink_d;
            scan_idx_q     <= scan_idx_d;
            count_tick_q   <= count_tick_d;
            adj_sec_tick_q <= adj_sec_tick_d;
            adj_min_tick_q <= adj_min_tick_d;
            clear_q        <= clear_d;
            an_mask_q      <= an_mask_d;
        end
    end

    assign bus.mode         = mode_q;
    assign bus.count_tick   = count_tick_q;
    assign bus.adj_sec_tick = adj_sec_tick_q;
    assign bus.adj_min_tick = adj_min_tick_q;
    assign bus.clear        = clear_q;
    assign bus.scan_idx     = scan_idx_q;
    assign bus.an_mask      = an_mask_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl with shortened dividers; strobes are matched
// against a queue of expected (cycle, kind) events.
module tb_stopwatch_ctrl;
    localparam int DIV_NORMAL = 10;
    localparam int DIV_ADJUST = 4;
    localparam int DIV_BLINK  = 3;
    localparam int DIV_SCAN   = 2;

    localparam logic [3:0] EV_COUNT = 4'b0001;
    localparam logic [3:0] EV_SEC   = 4'b0010;
    localparam logic [3:0] EV_MIN   = 4'b0100;
    localparam logic [3:0] EV_CLR   = 4'b1000;

    typedef struct {
        int         cycle;
        logic [3:0] kind;
    } event_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    event_t exp_q[$];

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .DIV_NORMAL(DIV_NORMAL),
        .DIV_ADJUST(DIV_ADJUST),
        .DIV_BLINK (DIV_BLINK),
        .DIV_SCAN  (DIV_SCAN),
        .CW        (27)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc - t0, obs, exp);
        end
    endtask

    function automatic int rel_cyc();
        return cyc - t0;
    endfunction

    task automatic wait_rel(input int n);
        while (rel_cyc() < n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] k);
        exp_q.push_back('{cycle: c, kind: k});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, 32'({bus.count_tick, bus.adj_sec_tick, bus.adj_min_tick, bus.clear}), 0);
        check({tag, "_mode"}, 32'(bus.mode), 0);
        check({tag, "_scan"}, 32'(bus.scan_idx), 0);
        check({tag, "_mask"}, 32'(bus.an_mask), 0);
    endtask

    // Strobe monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [3:0] seen;
        event_t     ev;
        seen = {bus.clear, bus.adj_min_tick, bus.adj_sec_tick, bus.count_tick};
        if (!reset && seen != 4'b0000) begin
            check("tick_onehot0", 32'($onehot0(seen[2:0])), 1);
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 32'(seen), 0);
            end else begin
                ev = exp_q.pop_front();
                check("strobe_kind", 32'(seen), 32'(ev.kind));
                check("strobe_cycle", rel_cyc(), ev.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.pause_pulse = 1'b0;
        bus.clear_pulse = 1'b0;
        bus.adj_level   = 1'b0;
        bus.sel_level   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        t0    = cyc;

        // Free run: second ticks every 10 cycles, scan steps every 2.
        for (int k = 1; k <= 4; k++) expect_ev(10 * k, EV_COUNT);
        for (int n = 0; n <= 10; n++) begin
            wait_rel(n);
            check("scan_idx", 32'(bus.scan_idx), (n / 2) % 4);
            check("run_mask", 32'(bus.an_mask), 0);
        end
        wait_rel(35);
        check("mode_run", 32'(bus.mode), 0);

        // Pause for 20 cycles after 6 counted cycles; 4 remain after resume.
        expect_ev(70, EV_COUNT);
        wait_rel(45); bus.pause_pulse = 1'b1;
        wait_rel(46); bus.pause_pulse = 1'b0;
        check("mode_paused_a", 32'(bus.mode), 1);
        wait_rel(55); check("mode_paused_b", 32'(bus.mode), 1);
        wait_rel(65); check("mode_paused_c", 32'(bus.mode), 1);
        bus.pause_pulse = 1'b1;
        wait_rel(66); bus.pause_pulse = 1'b0;
        check("mode_resumed", 32'(bus.mode), 0);

        // Adjust seconds for 12 cycles.
        wait_rel(70);
        bus.adj_level = 1'b1;
        bus.sel_level = 1'b0;
        for (int k = 1; k <= 3; k++) expect_ev(71 + 4 * k, EV_SEC);
        for (int n = 71; n <= 83; n++) begin
            wait_rel(n);
            check("mode_adj_sec", 32'(bus.mode), 2);
            check("mask_adj_sec", 32'(bus.an_mask), ((n / 3) % 2 == 1) ? 32'h3 : 32'h0);
        end

        // Switch to minutes without resetting the adjust divider; pause is ignored.
        bus.sel_level = 1'b1;
        for (int k = 0; k < 3; k++) expect_ev(87 + 4 * k, EV_MIN);
        for (int n = 84; n <= 95; n++) begin
            wait_rel(n);
            bus.pause_pulse = (n == 85);
            check("mode_adj_min", 32'(bus.mode), 3);
            check("mask_adj_min", 32'(bus.an_mask), ((n / 3) % 2 == 1) ? 32'hC : 32'h0);
        end
        bus.adj_level = 1'b0;
        expect_ev(105, EV_COUNT);
        wait_rel(96);
        check("mode_exit_run", 32'(bus.mode), 0);
        check("mask_exit_run", 32'(bus.an_mask), 0);

        // Adjust from PAUSED returns to PAUSED; clear with pause keeps mode.
        wait_rel(106); bus.pause_pulse = 1'b1;
        wait_rel(107); bus.pause_pulse = 1'b0;
        check("mode_paused_d", 32'(bus.mode), 1);
        wait_rel(110); bus.adj_level = 1'b1;
        wait_rel(111); check("mode_adj_from_pause", 32'(bus.mode), 3);
        wait_rel(113); bus.adj_level = 1'b0;
        wait_rel(114); check("mode_exit_paused", 32'(bus.mode), 1);
        wait_rel(116);
        bus.clear_pulse = 1'b1;
        bus.pause_pulse = 1'b1;
        expect_ev(117, EV_CLR);
        wait_rel(117);
        bus.clear_pulse = 1'b0;
        bus.pause_pulse = 1'b0;
        check("mode_after_clear_a", 32'(bus.mode), 1);
        wait_rel(118); check("mode_after_clear_b", 32'(bus.mode), 1);
        wait_rel(120); bus.pause_pulse = 1'b1;
        wait_rel(121); bus.pause_pulse = 1'b0;
        check("mode_run_after_clear", 32'(bus.mode), 0);
        expect_ev(131, EV_COUNT);

        // Reset while the normal divider sits at 7.
        wait_rel(138);
        check("scan_before_reset", 32'(bus.scan_idx), 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t0    = cyc;
        expect_ev(10, EV_COUNT);
        expect_ev(20, EV_COUNT);
        wait_rel(25);

        check("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
